fifo2_sync: RTL and testbench
=============================

// Module: fifo2_sync
// PURPOSE
//  Single-clock, parametrised successor to fifo1_sram for same-domain buffering.
//  Adds fill count, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags.
//  Adds a synchronous flush and a selectable first-word-fall-through (FWFT) read mode.
//  Sits between same-clock producer/consumer stages; storage is an internal register array.
// PARAMETERS
//  DSIZE      8    data width, bits
//  ASIZE      10   address width; depth = 2**ASIZE entries
//  AF_THRESH  2**ASIZE-4  walmost_full asserts when count >= AF_THRESH
//  AE_THRESH  4    ralmost_empty asserts when count <= AE_THRESH
//  FWFT       0    0 = registered read (1-cycle latency); 1 = fall-through head word
// PORTS
//  clk            in   1        single clock, rising edge
//  rst_n          in   1        async active-low reset
//  clear          in   1        sync flush; empties FIFO, clears sticky flags
//  winc           in   1        write request
//  wdata_in       in   DSIZE    write data
//  rinc           in   1        read/pop request
//  rdata          out  DSIZE    read data
//  wfull          out  1        count == 2**ASIZE
//  rempty         out  1        count == 0
//  walmost_full   out  1        count >= AF_THRESH
//  ralmost_empty  out  1        count <= AE_THRESH
//  count          out  ASIZE+1  current occupancy, 0..2**ASIZE
//  overflow       out  1        sticky: winc seen while wfull
//  underflow      out  1        sticky: rinc seen while rempty
// BEHAVIOUR
//  - Pointers wptr/rptr are ASIZE+1 bits; the low ASIZE bits address memory and the MSB is a wrap bit.
//    count = wptr - rptr, modulo 2**(ASIZE+1).
//  - Flags decode from registered pointers and update the cycle after the causing edge. They have no combinational path from winc/rinc.
//  - wr_ok = winc & ~wfull; rd_ok = rinc & ~rempty. Both are evaluated against pre-edge flags.
//  - Rejected winc: memory and wptr untouched; overflow <= 1 (sticky).
//  - Rejected rinc: rptr and rdata untouched; underflow <= 1 (sticky).
//  - Full + winc + rinc: the read is accepted and the write is rejected. Result: count-1 and overflow set.
//  - Empty + winc + rinc: the write is accepted and the read is rejected. Result: count=1 and underflow set.
//  - Non-full, non-empty + winc + rinc: both are accepted and count is unchanged.
//  - Pointer wrap at 2**ASIZE is seamless; the MSB toggles and the full/empty decode stays correct.
//  - FWFT=0: on an rd_ok edge, rdata <= mem[raddr]. rdata holds otherwise, including while empty.
//  - FWFT=1: rdata = mem[raddr] combinationally. It is valid whenever ~rempty; rd_ok advances rptr.
//  - Write-then-read of the same entry: a word written at edge N is readable from edge N+1, when rempty drops.
//  - clear (sync) overrides winc/rinc in its cycle: wptr=rptr=0, overflow=underflow=0.
//    rdata holds when FWFT=0. Memory contents are not cleared.
//  - Async reset applies immediately, mid-operation included: wptr=rptr=0, count=0, rempty=1, wfull=0.
//    Also on reset: ralmost_empty=1, walmost_full=0, overflow=underflow=0, rdata=0 (FWFT=0). Memory is not reset.
//  - Thresholds are elaboration constants and must satisfy AE_THRESH < AF_THRESH <= 2**ASIZE.
// TESTING
//  1 Reset, then 1024 winc with data i&8'hFF. Expect wfull=1, count=1024, walmost_full=1 from count=1020, overflow=0.
//  2 1025th winc while full: count stays 1024, overflow=1. Then 1024 rinc: rdata sequence 0..255 x4, rempty=1, count=0.
//  3 rinc while empty: underflow=1, rdata unchanged. Then winc+rinc on the same edge at empty: count=1, underflow stays 1.
//  4 Fill to 512, then 2000 cycles of simultaneous winc+rinc: count stays 512, data order preserved across pointer wrap.
//  5 At count=300, assert clear together with winc: count=0, rempty=1, overflow/underflow=0. Next write/read returns the new word.
//  6 FWFT=1 build: a single write of 8'hA5 gives rdata=8'hA5 with rempty=0 on the following cycle, before any rinc.
//    Also pulse rst_n low mid-burst: all flags return to reset values asynchronously.

Source files
------------

// File: rtl/fifo2_sync.sv
// Single-clock FIFO with fill count, almost-full/empty thresholds, sticky error flags and sync flush.
// Read latency 1 cycle (FWFT=0) or head word shown directly (FWFT=1); writes while full and reads while empty are dropped and flagged.
module fifo2_sync #(
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 10,
    parameter int AF_THRESH = 2**ASIZE - 4,
    parameter int AE_THRESH = 4,
    parameter bit FWFT      = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata_in,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             wfull,
    output logic             rempty,
    output logic             walmost_full,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);
    localparam int             DEPTH    = 2**ASIZE;
    localparam logic [ASIZE:0] LP_DEPTH = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] LP_AF    = (ASIZE+1)'(AF_THRESH);
    localparam logic [ASIZE:0] LP_AE    = (ASIZE+1)'(AE_THRESH);
    localparam logic [ASIZE:0] LP_ONE   = (ASIZE+1)'(1);

    logic [DSIZE-1:0] r_mem [0:DEPTH-1];
    logic [ASIZE:0]   r_wptr;
    logic [ASIZE:0]   r_rptr;
    logic             r_overflow;
    logic             r_underflow;

    logic [ASIZE:0]   w_count;
    logic [ASIZE-1:0] w_waddr;
    logic [ASIZE-1:0] w_raddr;
    logic             w_wr_ok;
    logic             w_rd_ok;

    // Occupancy and every flag come only from the registered pointers, so
    // nothing here depends combinationally on winc/rinc.
    assign w_count       = r_wptr - r_rptr;
    assign w_waddr       = r_wptr[ASIZE-1:0];
    assign w_raddr       = r_rptr[ASIZE-1:0];
    assign count         = w_count;
    assign wfull         = (w_count == LP_DEPTH);
    assign rempty        = (w_count == '0);
    assign walmost_full  = (w_count >= LP_AF);
    assign ralmost_empty = (w_count <= LP_AE);
    assign overflow      = r_overflow;
    assign underflow     = r_underflow;

    assign w_wr_ok = winc & ~wfull;
    assign w_rd_ok = rinc & ~rempty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clear) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + LP_ONE;
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + LP_ONE;
            end
            if (winc && wfull) begin
                r_overflow <= 1'b1;
            end
            if (rinc && rempty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Storage is deliberately not reset; a flush only moves the pointers.
    always_ff @(posedge clk) begin
        if (w_wr_ok && !clear) begin
            r_mem[w_waddr] <= wdata_in;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign rdata = r_mem[w_raddr];
        end else begin : g_reg
            logic [DSIZE-1:0] r_rdata;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rdata <= '0;
                end else if (w_rd_ok && !clear) begin
                    r_rdata <= r_mem[w_raddr];
                end
            end
            assign rdata = r_rdata;
        end
    endgenerate
endmodule

// File: tb/tb_fifo2_sync.sv
// Bench for fifo2_sync: registered-read 1024-deep instance against a queue model, plus a small FWFT instance.
module tb_fifo2_sync;
    localparam int DEPTH = 1024;
    localparam int AF    = DEPTH - 4;
    localparam int AE    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        clear, winc, rinc;
    logic [7:0]  wdata_in, rdata;
    logic        wfull, rempty, walmost_full, ralmost_empty, overflow, underflow;
    logic [10:0] count;

    logic        f_clear, f_winc, f_rinc;
    logic [7:0]  f_wdata, f_rdata;
    logic        f_wfull, f_rempty, f_walmost_full, f_ralmost_empty, f_overflow, f_underflow;
    logic [4:0]  f_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_q[$];
    logic       m_ovf, m_udf;
    logic [7:0] m_rdata;

    fifo2_sync #(.DSIZE(8), .ASIZE(10), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .winc(winc), .wdata_in(wdata_in),
        .rinc(rinc), .rdata(rdata), .wfull(wfull), .rempty(rempty),
        .walmost_full(walmost_full), .ralmost_empty(ralmost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    fifo2_sync #(.DSIZE(8), .ASIZE(4), .AF_THRESH(12), .AE_THRESH(4), .FWFT(1'b1)) u_dut_fwft (
        .clk(clk), .rst_n(rst_n), .clear(f_clear), .winc(f_winc), .wdata_in(f_wdata),
        .rinc(f_rinc), .rdata(f_rdata), .wfull(f_wfull), .rempty(f_rempty),
        .walmost_full(f_walmost_full), .ralmost_empty(f_ralmost_empty), .count(f_count),
        .overflow(f_overflow), .underflow(f_underflow)
    );

    // Reference: a plain queue; acceptance judged on the occupancy before the edge.
    task automatic model_edge(input logic w, input logic r, input logic c, input logic [7:0] d);
        int n;
        n = m_q.size();
        if (c) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (r && n != 0) m_rdata = m_q.pop_front();
            else if (r) m_udf = 1'b1;
            if (w && n != DEPTH) m_q.push_back(d);
            else if (w) m_ovf = 1'b1;
        end
    endtask

    function automatic logic [5:0] m_flags();
        int n;
        n = m_q.size();
        return {n == DEPTH, n == 0, n >= AF, n <= AE, m_ovf, m_udf};
    endfunction

    task automatic cycle(input logic w, input logic r, input logic c, input logic [7:0] d);
        winc = w; rinc = r; clear = c; wdata_in = d;
        model_edge(w, r, c, d);
        @(posedge clk); #1;
        winc = 1'b0; rinc = 1'b0; clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (count !== 11'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++;
        if ({wfull, rempty, walmost_full, ralmost_empty, overflow, underflow} !== 6'b010100) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 010100", {wfull, rempty, walmost_full, ralmost_empty, overflow, underflow});
        end
        n_checks++;
        if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
        n_checks++;
        if ({f_count, f_wfull, f_rempty, f_ralmost_empty} !== {5'd0, 3'b011}) begin
            n_fail++; $display("FAIL reset_fwft: got %b expected 00000011", {f_count, f_wfull, f_rempty, f_ralmost_empty});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 8'(i));
            n_checks++;
            if (walmost_full !== (i + 1 >= AF)) begin
                n_fail++; $display("FAIL fill_almost_full at %0d: got %b expected %b", i + 1, walmost_full, (i + 1 >= AF));
            end
        end
        n_checks++;
        if (count !== 11'd1024) begin n_fail++; $display("FAIL fill_count: got %0d expected 1024", count); end
        n_checks++;
        if ({wfull, overflow} !== 2'b10) begin n_fail++; $display("FAIL fill_full_ovf: got %b expected 10", {wfull, overflow}); end
    endtask

    task automatic test_overflow_drain();
        cycle(1'b1, 1'b0, 1'b0, 8'hEE);
        n_checks++;
        if (count !== 11'd1024 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL overflow: got count %0d ovf %b expected 1024 1", count, overflow);
        end
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 8'h00);
            n_checks++;
            if (rdata !== 8'(i)) begin n_fail++; $display("FAIL drain_data at %0d: got %h expected %h", i, rdata, 8'(i)); end
        end
        n_checks++;
        if (rempty !== 1'b1 || count !== 11'd0) begin
            n_fail++; $display("FAIL drain_empty: got rempty %b count %0d expected 1 0", rempty, count);
        end
    endtask

    task automatic test_underflow();
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        n_checks++;
        if (underflow !== 1'b1 || rdata !== 8'hFF) begin
            n_fail++; $display("FAIL underflow: got udf %b rdata %h expected 1 ff", underflow, rdata);
        end
        cycle(1'b1, 1'b1, 1'b0, 8'h77);
        n_checks++;
        if ({count, rempty, underflow} !== {11'd1, 1'b0, 1'b1} || rdata !== 8'hFF) begin
            n_fail++; $display("FAIL empty_wr_rd: got count %0d rempty %b udf %b rdata %h expected 1 0 1 ff", count, rempty, underflow, rdata);
        end
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        n_checks++;
        if (rdata !== 8'h77) begin n_fail++; $display("FAIL empty_wr_rd_data: got %h expected 77", rdata); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 512; i++) cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
        for (int i = 0; i < 2000; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 8'($urandom));
            n_checks++;
            if (count !== 11'd512 || rdata !== m_rdata) begin
                n_fail++; $display("FAIL wrap at %0d: got count %0d rdata %h expected 512 %h", i, count, rdata, m_rdata);
            end
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 212; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 8'h00);
            n_checks++;
            if (rdata !== m_rdata) begin n_fail++; $display("FAIL pre_clear_data at %0d: got %h expected %h", i, rdata, m_rdata); end
        end
        n_checks++;
        if (count !== 11'd300) begin n_fail++; $display("FAIL pre_clear_count: got %0d expected 300", count); end
        cycle(1'b1, 1'b0, 1'b1, 8'h99);
        n_checks++;
        if ({count, rempty, overflow, underflow} !== {11'd0, 3'b100}) begin
            n_fail++; $display("FAIL clear: got count %0d rempty %b ovf %b udf %b expected 0 1 0 0", count, rempty, overflow, underflow);
        end
        n_checks++;
        if (rdata !== m_rdata) begin n_fail++; $display("FAIL clear_rdata_hold: got %h expected %h", rdata, m_rdata); end
        cycle(1'b1, 1'b0, 1'b0, 8'h3C);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        n_checks++;
        if (rdata !== 8'h3C || rempty !== 1'b1) begin
            n_fail++; $display("FAIL post_clear: got rdata %h rempty %b expected 3c 1", rdata, rempty);
        end
    endtask

    task automatic test_random();
        int pw, pr;
        for (int i = 0; i < 3000; i++) begin
            pw = (i < 1500) ? 90 : 20;
            pr = (i < 1500) ? 20 : 90;
            cycle(1'($urandom_range(0, 99) < pw), 1'($urandom_range(0, 99) < pr),
                  1'($urandom_range(0, 999) == 0), 8'($urandom));
            n_checks++;
            if (count !== 11'(m_q.size())) begin n_fail++; $display("FAIL rand_count at %0d: got %0d expected %0d", i, count, m_q.size()); end
            n_checks++;
            if ({wfull, rempty, walmost_full, ralmost_empty, overflow, underflow} !== m_flags()) begin
                n_fail++; $display("FAIL rand_flags at %0d: got %b expected %b", i, {wfull, rempty, walmost_full, ralmost_empty, overflow, underflow}, m_flags());
            end
            n_checks++;
            if (rdata !== m_rdata) begin n_fail++; $display("FAIL rand_rdata at %0d: got %h expected %h", i, rdata, m_rdata); end
        end
    endtask

    task automatic test_fwft();
        f_winc = 1'b1; f_wdata = 8'hA5;
        @(posedge clk); #1;
        f_winc = 1'b0;
        n_checks++;
        if (f_rempty !== 1'b0 || f_rdata !== 8'hA5) begin
            n_fail++; $display("FAIL fwft_first: got rempty %b rdata %h expected 0 a5", f_rempty, f_rdata);
        end
        f_winc = 1'b1; f_wdata = 8'h5A;
        @(posedge clk); #1;
        f_winc = 1'b0;
        n_checks++;
        if (f_rdata !== 8'hA5 || f_count !== 5'd2) begin
            n_fail++; $display("FAIL fwft_head_hold: got rdata %h count %0d expected a5 2", f_rdata, f_count);
        end
        f_rinc = 1'b1;
        @(posedge clk); #1;
        f_rinc = 1'b0;
        n_checks++;
        if (f_rdata !== 8'h5A || f_count !== 5'd1) begin
            n_fail++; $display("FAIL fwft_pop: got rdata %h count %0d expected 5a 1", f_rdata, f_count);
        end
        for (int i = 0; i < 16; i++) begin
            f_winc = 1'b1; f_wdata = 8'($urandom);
            @(posedge clk); #1;
        end
        f_winc = 1'b0;
        n_checks++;
        if ({f_count, f_wfull, f_walmost_full, f_overflow} !== {5'd16, 3'b111} || f_rdata !== 8'h5A) begin
            n_fail++; $display("FAIL fwft_full: got count %0d full %b af %b ovf %b rdata %h expected 16 1 1 1 5a", f_count, f_wfull, f_walmost_full, f_overflow, f_rdata);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        winc = 1'b1; wdata_in = 8'h42; f_winc = 1'b1; f_wdata = 8'h24;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (count !== 11'd0) begin n_fail++; $display("FAIL async_rst_count: got %0d expected 0", count); end
        n_checks++;
        if ({wfull, rempty, walmost_full, ralmost_empty, overflow, underflow} !== 6'b010100) begin
            n_fail++; $display("FAIL async_rst_flags: got %b expected 010100", {wfull, rempty, walmost_full, ralmost_empty, overflow, underflow});
        end
        n_checks++;
        if (rdata !== 8'h00) begin n_fail++; $display("FAIL async_rst_rdata: got %h expected 00", rdata); end
        n_checks++;
        if ({f_count, f_wfull, f_rempty, f_walmost_full, f_ralmost_empty, f_overflow, f_underflow} !== {5'd0, 6'b010100}) begin
            n_fail++; $display("FAIL async_rst_fwft: got %b expected 00000010100", {f_count, f_wfull, f_rempty, f_walmost_full, f_ralmost_empty, f_overflow, f_underflow});
        end
        m_q.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_rdata = 8'h00;
        winc = 1'b0; f_winc = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 8'hC3);
        cycle(1'b1, 1'b0, 1'b0, 8'h3C);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        n_checks++;
        if (rdata !== 8'hC3 || count !== 11'd1) begin
            n_fail++; $display("FAIL post_rst: got rdata %h count %0d expected c3 1", rdata, count);
        end
    endtask

    initial begin
        clear = 1'b0; winc = 1'b0; rinc = 1'b0; wdata_in = 8'h00;
        f_clear = 1'b0; f_winc = 1'b0; f_rinc = 1'b0; f_wdata = 8'h00;
        m_ovf = 1'b0; m_udf = 1'b0; m_rdata = 8'h00;
        test_reset();
        test_fill();
        test_overflow_drain();
        test_underflow();
        test_wrap();
        test_clear();
        test_random();
        test_fwft();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
